// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART frame receiver.
// State encoding, oversampling constants and small helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK_WAIT
    } state_e;

    localparam int OVS = 16;

    localparam logic [3:0] SMP_A    = 4'd7;
    localparam logic [3:0] SMP_B    = 4'd8;
    localparam logic [3:0] SMP_C    = 4'd9;
    localparam logic [3:0] CNT_LAST = 4'(OVS - 1);

    localparam logic [3:0] MIN_DATA = 4'd5;
    localparam logic [3:0] MAX_DATA = 4'd9;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [3:0] clamp_size(input logic [3:0] s);
        if (s < MIN_DATA) return MIN_DATA;
        if (s > MAX_DATA) return MAX_DATA;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchronizer and 3-sample majority voter for the UART receiver.
// bit_val_o is the vote, meaningful on the tick where the bit counter is 9.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    input  logic       b_tick_i,
    input  logic [3:0] b_cnt_i,
    output logic       rx_s_o,
    output logic       bit_val_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_a_q;
    logic                   s_b_q;

    assign sync_d    = SYNC_STAGES'({sync_q, rx_i});
    assign rx_s_o    = sync_q[SYNC_STAGES-1];
    assign bit_val_o = maj3(s_a_q, s_b_q, rx_s_o);

    // Synchronize rx and capture the first two of the three bit samples.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            s_a_q  <= 1'b1;
            s_b_q  <= 1'b1;
        end else begin
            sync_q <= sync_d;
            if (b_tick_i && b_cnt_i == SMP_A) s_a_q <= rx_s_o;
            if (b_tick_i && b_cnt_i == SMP_B) s_b_q <= rx_s_o;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Configurable UART frame receiver: 5-9 data bits, optional parity,
// 1/2 stop bits, 16x oversampling, break detection and idle timeout.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DW          = 9,
    parameter int TOW         = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           b_tick,
    input  logic           rx,
    input  logic [3:0]     data_size,
    input  logic           parity_en,
    input  logic           parity_odd,
    input  logic           stop2,
    input  logic [TOW-1:0] timeout_bits,
    output logic [DW-1:0]  dout,
    output logic           dout_valid,
    output logic           parity_err,
    output logic           frame_err,
    output logic           break_err,
    output logic           timeout,
    output logic           busy
);

    localparam logic [TOW+3:0] TO_ONE = {{(TOW + 3){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [3:0]      b_cnt_q, b_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            bit_q, bit_d;
    logic            par_q, par_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            berr_q, berr_d;
    logic            to_q, to_d;
    logic            armed_q, armed_d;
    logic [TOW+3:0]  to_cnt_q, to_cnt_d;

    logic            rx_s;
    logic            vote;
    logic [3:0]      nbits;
    logic [3:0]      shamt;
    logic [DW-1:0]   data_rj;
    logic [TOW+3:0]  to_lim;
    logic            at9;
    logic            at15;
    logic            last_bit;
    logic            complete;
    logic            is_brk;

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .rx_i      (rx),
        .b_tick_i  (b_tick),
        .b_cnt_i   (b_cnt_q),
        .rx_s_o    (rx_s),
        .bit_val_o (vote)
    );

    assign nbits    = clamp_size(data_size);
    assign shamt    = 4'(DW) - nbits;
    assign data_rj  = shreg_q >> shamt;
    assign to_lim   = {timeout_bits, 4'b0000};
    assign at9      = b_tick && (b_cnt_q == SMP_C);
    assign at15     = b_tick && (b_cnt_q == CNT_LAST);
    assign last_bit = (bit_cnt_q == nbits - 4'd1);

    assign complete = en && at9 &&
                      ((state_q == ST_STOP1 && !(vote && stop2)) ||
                       state_q == ST_STOP2);
    assign is_brk   = (state_q == ST_STOP1) && !vote &&
                      (data_rj == '0) && !(parity_en && par_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; a low enable always parks the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (b_tick && !rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (at9 && vote)  state_d = ST_IDLE;
                else if (at15)    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at15 && last_bit)
                    state_d = parity_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (at15) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (complete)  state_d = is_brk ? ST_BRK_WAIT : ST_IDLE;
                else if (at15) state_d = ST_STOP2;
            end
            ST_STOP2: begin
                if (complete) state_d = ST_IDLE;
            end
            ST_BRK_WAIT: begin
                if (b_tick && rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) state_d = ST_IDLE;
    end

    // Per-state datapath actions, completion results and idle timeout.
    always_comb begin
        b_cnt_d   = b_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        bit_d     = bit_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        berr_d    = berr_q;
        to_d      = 1'b0;
        armed_d   = armed_q;
        to_cnt_d  = to_cnt_q;
        busy      = (state_q != ST_IDLE);
        if (en) begin
            if (b_tick) b_cnt_d = b_cnt_q + 4'd1;
            if (state_d != state_q || state_q == ST_IDLE ||
                state_q == ST_BRK_WAIT)
                b_cnt_d = '0;
            if (at9) bit_d = vote;
            if (state_q == ST_IDLE && state_d == ST_START) begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end
            if (state_q == ST_DATA && at15) begin
                shreg_d   = {bit_q, shreg_q[DW-1:1]};
                bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            end
            if (state_q == ST_PARITY && at9) par_d = vote;
            if (complete) begin
                valid_d  = 1'b1;
                dout_d   = data_rj;
                perr_d   = parity_en &&
                           (par_q != ((^data_rj) ^ parity_odd));
                ferr_d   = !vote;
                berr_d   = is_brk;
                armed_d  = 1'b1;
                to_cnt_d = '0;
            end else if (state_q == ST_IDLE && state_d == ST_IDLE &&
                         armed_q && b_tick && timeout_bits != '0) begin
                if (to_cnt_q + TO_ONE == to_lim) begin
                    to_d     = 1'b1;
                    armed_d  = 1'b0;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
        end else begin
            b_cnt_d   = '0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            armed_d   = 1'b0;
        end
    end

    // Datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_cnt_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            bit_q     <= 1'b0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            berr_q    <= 1'b0;
            to_q      <= 1'b0;
            armed_q   <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            b_cnt_q   <= b_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            berr_q    <= berr_d;
            to_q      <= to_d;
            armed_q   <= armed_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_err  = berr_q;
    assign timeout    = to_q;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Configurable UART frame receiver. It is the receive-side counterpart to the team's fixed-format 8N1 transmitter/receiver pair. It accepts 5–9 data bits, optional parity and 1 or 2 stop bits, uses 16x oversampling with majority-vote bit decisions, and detects framing, parity and break conditions plus an idle timeout. It sits between the shared baud generator (b_tick) and the RX FIFO write port.

Parameters:
DW, 9, width of dout; maximum supported data bits
TOW, 6, width of timeout_bits
SYNC_STAGES, 2, number of input synchronizer flops on rx

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
en  in  1  receiver enable; 0 forces IDLE
b_tick  in  1  16x-oversample tick from the baud generator
rx  in  1  asynchronous serial input, idle high
data_size  in  4  data bits; values <5 act as 5, values >9 act as 9
parity_en  in  1  parity bit present
parity_odd  in  1  1 = odd parity, 0 = even parity
stop2  in  1  two stop bits
timeout_bits  in  TOW  idle timeout in bit times; 0 disables
dout  out  DW  received data, right-justified, upper bits 0
dout_valid  out  1  one-cycle pulse; dout and error flags valid
parity_err  out  1  qualified by dout_valid
frame_err  out  1  qualified by dout_valid
break_err  out  1  qualified by dout_valid
timeout  out  1  one-cycle idle-timeout pulse
busy  out  1  state != IDLE

Behaviour:
- Reset: rst_n sampled on posedge clk only.
  - Values after reset: state=IDLE, b_cnt=0, bit_cnt=0, dout=0, all flags/pulses 0, busy=0.
  - Synchronizer flops reset to 1.
  - Timeout is disarmed.
  - Reset mid-frame abandons the frame; no dout_valid is issued.
- rx passes through SYNC_STAGES flops, giving rx_s. All decisions use rx_s.
- b_cnt (4-bit) advances only on b_tick.
- Per bit, rx_s is sampled at b_cnt 7, 8 and 9. The bit value is the majority of the 3 samples.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE: on b_tick with rx_s=0, go to START and set b_cnt=0.
  - START: on the b_tick at b_cnt=9, if the majority is 1 (false start), return to IDLE with no output. Otherwise, at b_cnt=15 go to DATA with b_cnt=0 and bit_cnt=0.
  - DATA: LSB first. Each bit decision is shifted into the data register at b_cnt=15. After bit data_size-1, go to PARITY if parity_en, else STOP1.
  - PARITY: the parity bit is checked against the XOR of the data bits; for odd parity the expected bit is inverted. Go to STOP1 at b_cnt=15.
  - STOP1: at b_cnt=9, frame_err is set if the majority is 0.
    - If stop2 and the bit is good, go to STOP2 at b_cnt=15.
    - Otherwise complete at b_cnt=9 (early completion, so back-to-back frames are tolerated).
  - STOP2: its own majority decision at b_cnt=9 sets frame_err; the frame completes there.
  - Completion: dout_valid=1 for exactly one clk.
    - dout, parity_err, frame_err and break_err update on the same edge and hold until the next completion.
    - Next state is IDLE, or BRK_WAIT on a break.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0 gives break_err=1, frame_err=1, dout=0.
  - The block then enters BRK_WAIT and stays until a b_tick samples rx_s=1, then goes to IDLE.
  - Exactly one dout_valid per break.
- Latency: for 8N1, dout_valid is high on the cycle after the 154th b_tick following the start-detect tick (16+128+10).
- Timeout: armed by each dout_valid.
  - While in IDLE, b_ticks are counted.
  - On reaching timeout_bits*16, timeout pulses once and disarms.
  - A new start bit clears the count.
  - timeout_bits=0 never pulses.
- en=0: the next edge forces IDLE, clears counters and disarms timeout; pulses stay 0; dout and flags hold.
- Config inputs must be stable while busy; changes mid-frame are undefined.
- b_tick held high continuously is legal (one oversample per clk).

Decomposition:
- Package uart_pkg:
  - state encoding
  - OVS=16
  - sample indices 7/8/9
  - MIN_DATA=5 and MAX_DATA=9
- One sub-module, uart_rx_sampler: SYNC_STAGES synchronizer plus 3-sample majority voter. Outputs rx_s and bit_val.

Test Plan:
- 8N1 byte 0xA5, b_tick=1: dout=0x0A5, one dout_valid 154 ticks after start-detect, all errors 0.
- 7 data bits, even parity, byte 0x41 sent with parity bit 1: dout=0x041, parity_err=1; repeat with parity 0, parity_err=0.
- 4-tick low glitch on an idle line: no dout_valid, busy returns to 0 by tick 10.
- Line low for 12 bit times (8N1): one dout_valid with dout=0, frame_err=1, break_err=1. No further valid until rx is high; the next byte 0x3C is received correctly.
- timeout_bits=4 after byte 0x55, line idle: timeout pulses exactly once, 64 b_ticks after dout_valid. It does not pulse with timeout_bits=0.
- Single-tick low glitch at sample 8 of data bit 3 of 0xFF: dout=0x0FF. rst_n low mid-frame: no valid, outputs 0, the next frame is received cleanly.
